fetch_entry_queue: RTL and testbench

- Frontend-side producer of the fetch-to-decode handshake: turns 32-bit instruction-memory fetch words into one-instruction-per-entry fetch entries for the decode stage.
- Realigns 16-bit (RVC) and 32-bit instructions, including 32-bit instructions that straddle two fetch words.
- Buffers entries in a small FIFO and drives valid/ready towards decode.
- Sits between the I$ response path and the decode stage; flushed by the controller.

---
 rtl/fetch_entry_queue_pkg.sv | 28 ++
 rtl/fetch_entry_queue_instr_realigner.sv | 133 +++++++++++++
 rtl/fetch_entry_queue.sv | 126 ++++++++++++
 tb/tb_fetch_entry_queue.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_entry_queue_pkg.sv
// Shared frontend definitions for the fetch entry queue.
//   fetch_entry_t    : one decoded-side entry (raw instruction, PC, fault flag)
//   realign_state_e  : realigner state (IDLE, HALF = holding a lower 16-bit half)
//   is_compressed()  : RVC opcode test on a 16-bit parcel
package fetch_entry_queue_pkg;

  // Entries carry a full-width address; modules cast to their own VLEN.
  localparam int unsigned FE_ADDR_W = 64;

  // Bits [1:0] of a parcel equal to this value mark a 32-bit instruction.
  localparam logic [1:0] OPC_UNCOMPRESSED = 2'b11;

  typedef enum logic {
    RA_IDLE = 1'b0,
    RA_HALF = 1'b1
  } realign_state_e;

  typedef struct packed {
    logic [31:0]          instr;
    logic [FE_ADDR_W-1:0] addr;
    logic                 ex_valid;
  } fetch_entry_t;

  function automatic logic is_compressed(input logic [15:0] parcel);
    return parcel[1:0] != OPC_UNCOMPRESSED;
  endfunction

endpackage

// File: rtl/fetch_entry_queue_instr_realigner.sv
// Instruction realigner: splits one accepted 32-bit fetch word into up to two
// program-ordered entries and keeps the lower half of a word-straddling
// 32-bit instruction between words.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   flush_i         return to IDLE, drop the held half
//   accept_i        fetch word is consumed this cycle
//   addr_i/data_i   fetch word address and data
//   ex_i            fetch fault on this word
//   entry0_o/1_o    produced entries, entry0 first in program order
//   valid_o         entry valids; valid_o[1] implies valid_o[0]
module instr_realigner
  import fetch_entry_queue_pkg::*;
#(
  parameter int unsigned VLEN = 64,
  parameter int unsigned RVC  = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               accept_i,
  input  logic [VLEN-1:0]    addr_i,
  input  logic [31:0]        data_i,
  input  logic               ex_i,
  output fetch_entry_t       entry0_o,
  output fetch_entry_t       entry1_o,
  output logic [1:0]         valid_o
);

  logic [FE_ADDR_W-1:0] addr_full;
  assign addr_full = FE_ADDR_W'(addr_i);

  if (RVC != 0) begin : g_rvc
    realign_state_e       state_q, state_d;
    logic [15:0]          held_q, held_d;
    logic [FE_ADDR_W-1:0] held_pc_q, held_pc_d;
    fetch_entry_t         first_e, up_e;
    logic                 first_v, up_v, do_upper;
    logic [FE_ADDR_W-1:0] upper_pc;

    assign upper_pc = {addr_full[FE_ADDR_W-1:2], 2'b10};

    always_comb begin
      state_d   = state_q;
      held_d    = held_q;
      held_pc_d = held_pc_q;
      first_e   = '0;
      up_e      = '0;
      first_v   = 1'b0;
      up_v      = 1'b0;
      do_upper  = 1'b0;
      if (accept_i) begin
        state_d = RA_IDLE;
        if (ex_i) begin
          // A faulting word yields one marker entry; a pending half is
          // reported at its own PC since that is where the instruction starts.
          first_v          = 1'b1;
          first_e.addr     = (state_q == RA_HALF) ? held_pc_q : addr_full;
          first_e.ex_valid = 1'b1;
        end else begin
          if (!addr_full[1]) begin
            first_v = 1'b1;
            if (state_q == RA_HALF) begin
              first_e.instr = {data_i[15:0], held_q};
              first_e.addr  = held_pc_q;
              do_upper      = 1'b1;
            end else if (is_compressed(data_i[15:0])) begin
              first_e.instr = {16'h0000, data_i[15:0]};
              first_e.addr  = addr_full;
              do_upper      = 1'b1;
            end else begin
              first_e.instr = data_i;
              first_e.addr  = addr_full;
            end
          end else begin
            // Entry at the upper half (also a discontinuity out of HALF):
            // any held half is simply abandoned.
            do_upper = 1'b1;
          end
          if (do_upper) begin
            if (is_compressed(data_i[31:16])) begin
              up_v       = 1'b1;
              up_e.instr = {16'h0000, data_i[31:16]};
              up_e.addr  = upper_pc;
            end else begin
              state_d   = RA_HALF;
              held_d    = data_i[31:16];
              held_pc_d = upper_pc;
            end
          end
        end
      end
      // Compact so that slot 0 is always the oldest produced entry.
      if (first_v) begin
        entry0_o = first_e;
        entry1_o = up_e;
        valid_o  = {up_v, 1'b1};
      end else begin
        entry0_o = up_e;
        entry1_o = '0;
        valid_o  = {1'b0, up_v};
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q   <= RA_IDLE;
        held_q    <= '0;
        held_pc_q <= '0;
      end else if (flush_i) begin
        state_q   <= RA_IDLE;
      end else begin
        state_q   <= state_d;
        held_q    <= held_d;
        held_pc_q <= held_pc_d;
      end
    end
  end else begin : g_norvc
    // Without compressed support every word is exactly one instruction.
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_ni, flush_i};

    always_comb begin
      entry0_o          = '0;
      entry0_o.instr    = ex_i ? 32'h0 : data_i;
      entry0_o.addr     = addr_full;
      entry0_o.ex_valid = ex_i;
      entry1_o          = '0;
      valid_o           = {1'b0, accept_i};
    end
  end

endmodule

// File: rtl/fetch_entry_queue.sv
// Fetch entry queue: realigns 32-bit fetch words into one-instruction entries
// and buffers them in a circular FIFO towards decode.
// Optional macro FETCH_QUEUE_BYPASS_EN: when the FIFO is empty the first new
// entry is presented to decode in the same cycle and skips the FIFO if taken.
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   flush_i                        drop held half and all queued entries
//   fetch_valid_i/fetch_ready_o    fetch word handshake
//   fetch_addr_i/data_i/ex_valid_i fetch word payload
//   fetch_entry_valid_o/ready_i    entry handshake towards decode
//   fetch_entry_instr_o/addr_o/ex_valid_o  entry payload (zero when not valid)
module fetch_entry_queue
  import fetch_entry_queue_pkg::*;
#(
  parameter int unsigned VLEN  = 64,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned RVC   = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              fetch_valid_i,
  output logic              fetch_ready_o,
  input  logic [VLEN-1:0]   fetch_addr_i,
  input  logic [31:0]       fetch_data_i,
  input  logic              fetch_ex_valid_i,
  output logic              fetch_entry_valid_o,
  input  logic              fetch_entry_ready_i,
  output logic [31:0]       fetch_entry_instr_o,
  output logic [VLEN-1:0]   fetch_entry_addr_o,
  output logic              fetch_entry_ex_valid_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW-1:0]    wr_idx, wr_idx1, rd_idx;
  logic [PTR_W-1:0] count;
  logic [PTR_W:0]   free_slots;
  logic             empty, full, fifo_pop, accept;
  fetch_entry_t     rl_entry0, rl_entry1, push_e0, push_e1, out_entry;
  logic [1:0]       rl_valid, push_v, n_push;
  logic             out_valid;

  assign wr_idx  = wr_ptr_q[AW-1:0];
  assign wr_idx1 = wr_idx + AW'(1);
  assign rd_idx  = rd_ptr_q[AW-1:0];
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
  assign count   = full ? PTR_W'(DEPTH) : {1'b0, wr_idx - rd_idx};

  // Only FIFO pops count toward free space; a bypassed entry never occupies
  // a slot, and leaving it out keeps fetch_ready_o free of a loop through
  // the bypass path.
  assign fifo_pop   = !empty && fetch_entry_ready_i;
  assign free_slots = (PTR_W + 1)'(DEPTH) - {1'b0, count} + (PTR_W + 1)'(fifo_pop);

  // Two free slots guarantee room for the worst case of two entries per word.
  assign fetch_ready_o = (free_slots >= (PTR_W + 1)'(2)) && !flush_i;
  assign accept        = fetch_valid_i && fetch_ready_o;

  instr_realigner #(
    .VLEN (VLEN),
    .RVC  (RVC)
  ) u_realigner (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .flush_i  (flush_i),
    .accept_i (accept),
    .addr_i   (fetch_addr_i),
    .data_i   (fetch_data_i),
    .ex_i     (fetch_ex_valid_i),
    .entry0_o (rl_entry0),
    .entry1_o (rl_entry1),
    .valid_o  (rl_valid)
  );

  always_comb begin
    push_e0   = rl_entry0;
    push_e1   = rl_entry1;
    push_v    = rl_valid;
    out_entry = mem_q[rd_idx];
    out_valid = !empty;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (empty) begin
      out_entry = rl_entry0;
      out_valid = rl_valid[0];
      if (rl_valid[0] && fetch_entry_ready_i) begin
        push_e0 = rl_entry1;
        push_e1 = '0;
        push_v  = {1'b0, rl_valid[1]};
      end
    end
`endif
  end

  assign n_push = {1'b0, push_v[0]} + {1'b0, push_v[1]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(n_push);
      rd_ptr_q <= rd_ptr_q + PTR_W'(fifo_pop);
    end
  end

  // Storage needs no reset: pushes only happen on accepted words, which
  // never coincide with a flush, and empty slots are never presented.
  always_ff @(posedge clk_i) begin
    if (push_v[0]) mem_q[wr_idx]  <= push_e0;
    if (push_v[1]) mem_q[wr_idx1] <= push_e1;
  end

  assign fetch_entry_valid_o    = out_valid;
  assign fetch_entry_instr_o    = out_valid ? out_entry.instr : 32'h0;
  assign fetch_entry_addr_o     = out_valid ? VLEN'(out_entry.addr) : '0;
  assign fetch_entry_ex_valid_o = out_valid && out_entry.ex_valid;

endmodule

// File: tb/tb_fetch_entry_queue.sv
module tb_fetch_entry_queue;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [63:0] fetch_addr_i;
  logic [31:0] fetch_data_i;
  logic        fetch_ex_valid_i;
  logic        fetch_entry_valid_o;
  logic        fetch_entry_ready_i;
  logic [31:0] fetch_entry_instr_o;
  logic [63:0] fetch_entry_addr_o;
  logic        fetch_entry_ex_valid_o;

  fetch_entry_queue #(
    .VLEN  (64),
    .DEPTH (DEPTH),
    .RVC   (1)
  ) dut (
    .clk_i                  (clk_i),
    .rst_ni                 (rst_ni),
    .flush_i                (flush_i),
    .fetch_valid_i          (fetch_valid_i),
    .fetch_ready_o          (fetch_ready_o),
    .fetch_addr_i           (fetch_addr_i),
    .fetch_data_i           (fetch_data_i),
    .fetch_ex_valid_i       (fetch_ex_valid_i),
    .fetch_entry_valid_o    (fetch_entry_valid_o),
    .fetch_entry_ready_i    (fetch_entry_ready_i),
    .fetch_entry_instr_o    (fetch_entry_instr_o),
    .fetch_entry_addr_o     (fetch_entry_addr_o),
    .fetch_entry_ex_valid_o (fetch_entry_ex_valid_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: expected entries in program order plus the pending half.
  typedef struct {
    logic [31:0] instr;
    logic [63:0] addr;
    logic        ex;
  } exp_t;

  exp_t        exp_q[$];
  logic        held_v;
  logic [15:0] held;
  logic [63:0] held_pc;
  int          errors = 0;
  int          checks = 0;
  int          rdy_mode = 0;  // 0: decode always ready, 1: never ready, 2: random

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic pick_rdy();
    if (rdy_mode == 0) return 1'b1;
    if (rdy_mode == 1) return 1'b0;
    return $urandom_range(0, 3) != 0;
  endfunction

  function automatic logic [15:0] rand_half();
    logic [15:0] h;
    h = 16'($urandom);
    if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
    else h[1:0] = 2'($urandom_range(0, 2));
    return h;
  endfunction

  task automatic push_exp(input logic [31:0] instr, input logic [63:0] addr, input logic ex);
    exp_t e;
    e.instr = instr;
    e.addr  = addr;
    e.ex    = ex;
    exp_q.push_back(e);
  endtask

  // Entries an accepted word must produce, from the instruction-length rules.
  task automatic model_word(input logic [63:0] a, input logic [31:0] d, input logic ex);
    logic [15:0] lo, hi;
    logic        do_upper;
    lo = d[15:0];
    hi = d[31:16];
    do_upper = 1'b0;
    if (ex) begin
      push_exp(32'h0, held_v ? held_pc : a, 1'b1);
      held_v = 1'b0;
      return;
    end
    if (a[1] == 1'b0) begin
      if (held_v) begin
        push_exp({lo, held}, held_pc, 1'b0);
        do_upper = 1'b1;
      end else if (lo[1:0] != 2'b11) begin
        push_exp({16'h0, lo}, a, 1'b0);
        do_upper = 1'b1;
      end else begin
        push_exp(d, a, 1'b0);
      end
    end else begin
      do_upper = 1'b1;
    end
    held_v = 1'b0;
    if (do_upper) begin
      if (hi[1:0] != 2'b11) begin
        push_exp({16'h0, hi}, a | 64'h2, 1'b0);
      end else begin
        held_v  = 1'b1;
        held    = hi;
        held_pc = a | 64'h2;
      end
    end
  endtask

  // One clock cycle: drive at the falling edge, check 1 time unit later.
  task automatic step(input logic v, input logic [63:0] a, input logic [31:0] d,
                      input logic ex, input logic rdy, input logic fl, output logic acc);
    int   sz;
    int   free_n;
    logic exp_ready;
    logic exp_valid;
    @(negedge clk_i);
    fetch_valid_i       = v;
    fetch_addr_i        = a;
    fetch_data_i        = d;
    fetch_ex_valid_i    = ex;
    fetch_entry_ready_i = rdy;
    flush_i             = fl;
    #1;
    sz        = exp_q.size();
    free_n    = DEPTH - sz + ((sz > 0 && rdy) ? 1 : 0);
    exp_ready = (free_n >= 2) && !fl;
    chk("fetch_ready", fetch_ready_o, exp_ready);
    acc = v && fetch_ready_o;
    if (acc) model_word(a, d, ex);
`ifdef FETCH_QUEUE_BYPASS_EN
    exp_valid = exp_q.size() > 0;
`else
    exp_valid = sz > 0;
`endif
    chk("entry_valid", fetch_entry_valid_o, exp_valid);
    if (fetch_entry_valid_o && exp_q.size() > 0) begin
      chk("entry_instr", fetch_entry_instr_o, exp_q[0].instr);
      chk("entry_addr", fetch_entry_addr_o, exp_q[0].addr);
      chk("entry_ex", fetch_entry_ex_valid_o, exp_q[0].ex);
      if (rdy) void'(exp_q.pop_front());
    end
    if (fl) begin
      exp_q.delete();
      held_v = 1'b0;
    end
  endtask

  task automatic send(input logic [63:0] a, input logic [31:0] d, input logic ex);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 40) begin
      step(1'b1, a, d, ex, pick_rdy(), 1'b0, acc);
      n++;
    end
    chk("send_timeout", acc, 1'b1);
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      step(1'b0, 64'h0, 32'h0, 1'b0, 1'b1, 1'b0, acc);
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'h0);
    step(1'b0, 64'h0, 32'h0, 1'b0, 1'b1, 1'b0, acc);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni              = 1'b0;
    fetch_valid_i       = 1'b0;
    flush_i             = 1'b0;
    fetch_entry_ready_i = 1'b0;
    #1;
    chk("rst_valid", fetch_entry_valid_o, 1'b0);
    chk("rst_ready", fetch_ready_o, 1'b1);
    chk("rst_instr", fetch_entry_instr_o, 32'h0);
    chk("rst_addr", fetch_entry_addr_o, 64'h0);
    chk("rst_ex", fetch_entry_ex_valid_o, 1'b0);
    exp_q.delete();
    held_v = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    logic        acc;
    logic [63:0] pc;
    logic [31:0] d;
    logic        ex;
    int          r;
    rst_ni              = 1'b0;
    flush_i             = 1'b0;
    fetch_valid_i       = 1'b0;
    fetch_addr_i        = '0;
    fetch_data_i        = '0;
    fetch_ex_valid_i    = 1'b0;
    fetch_entry_ready_i = 1'b0;
    held_v              = 1'b0;
    held                = '0;
    held_pc             = '0;
    repeat (2) @(negedge clk_i);
    do_reset();

    // Two 32-bit instructions.
    rdy_mode = 0;
    send(64'h1000, 32'h0000_0013, 1'b0);
    send(64'h1004, 32'h0010_0093, 1'b0);
    drain();

    // Two compressed instructions in one word.
    send(64'h2000, 32'h4501_4501, 1'b0);
    drain();

    // 32-bit instruction straddling two words.
    send(64'h3000, 32'h0013_4501, 1'b0);
    send(64'h3004, 32'h4501_0000, 1'b0);
    drain();

    // Backpressure: fill the FIFO, words must be refused, nothing lost.
    rdy_mode = 1;
    send(64'h4000, 32'h4501_4501, 1'b0);
    send(64'h4004, 32'h4601_4701, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 64'h4008, 32'h4801_4901, 1'b0, 1'b0, 1'b0, acc);
      chk("full_refuse", acc, 1'b0);
    end
    rdy_mode = 0;
    send(64'h4008, 32'h4801_4901, 1'b0);
    drain();

    // Fault while a half is held: single entry at the held PC, then IDLE.
    send(64'h5000, 32'h0013_4501, 1'b0);
    send(64'h5004, 32'h1234_5678, 1'b1);
    send(64'h5008, 32'h0000_0013, 1'b0);
    drain();

    // Flush with three queued entries; word in the flush cycle is refused.
    rdy_mode = 1;
    send(64'h6000, 32'h4501_4501, 1'b0);
    send(64'h6004, 32'h0000_0013, 1'b0);
    step(1'b1, 64'h6008, 32'h0000_0013, 1'b0, 1'b0, 1'b1, acc);
    chk("flush_accept", acc, 1'b0);
    step(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
    chk("post_flush_valid", fetch_entry_valid_o, 1'b0);
    rdy_mode = 0;
    send(64'h7002, 32'h0013_4501, 1'b0);
    send(64'h7004, 32'h4501_0000, 1'b0);
    drain();

    // Randomised traffic with random decode backpressure.
    rdy_mode = 2;
    pc = 64'h8000;
    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_reset();
      r = $urandom_range(0, 31);
      if (r == 0) begin
        step(1'b0, 64'h0, 32'h0, 1'b0, pick_rdy(), 1'b1, acc);
      end else if (r < 4) begin
        step(1'b0, 64'h0, 32'h0, 1'b0, pick_rdy(), 1'b0, acc);
      end else begin
        if ($urandom_range(0, 7) == 0) pc = {32'h0, $urandom() & 32'hFFFF_FFFE};
        d  = {rand_half(), rand_half()};
        ex = ($urandom_range(0, 15) == 0);
        send(pc, d, ex);
        pc = {pc[63:2], 2'b00} + 64'h4;
      end
    end
    rdy_mode = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
